// File: rtl/apex7_eval_sched.sv
// apex7_eval_sched: round-robin scheduler time-sharing one combinational apex7 netlist.
// Define APEX7_SIG_EN to add a response-signature MISR with sig_clr/sig ports.
module apex7_eval_sched #(
  parameter int NREQ   = 4,
  parameter int PI_W   = 49,
  parameter int PO_W   = 37,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*PI_W-1:0]     req_pi,
  output logic [PI_W-1:0]          dut_pi,
  input  logic [PO_W-1:0]          dut_po,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PO_W-1:0]          rsp_po,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy
`ifdef APEX7_SIG_EN
  ,
  input  logic                     sig_clr,
  output logic [PO_W-1:0]          sig
`endif
);

  localparam int IDW = $clog2(NREQ);

  generate
    if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
      $error("apex7_eval_sched: SETTLE must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [IDW-1:0]      r_rr_ptr;
  logic [3:0]          r_cnt;
  logic [PI_W-1:0]     r_dut_pi;
  logic                r_rsp_valid;
  logic [PO_W-1:0]     r_rsp_po;
  logic [IDW-1:0]      r_rsp_id;

  logic [2*NREQ-1:0]   w_dbl;
  logic                w_found;
  logic [IDW:0]        w_sum;
  logic [IDW-1:0]      w_winner;
  logic [IDW-1:0]      w_rr_next;
  logic [PI_W-1:0]     w_sel_pi;
  logic                w_accept;
  logic                w_rsp_hs;

  // Rotate requests so bit k is requester (rr_ptr+k) mod NREQ; first set bit wins.
  always_comb begin
    w_dbl    = {req_valid, req_valid} >> r_rr_ptr;
    w_found  = 1'b0;
    w_sum    = '0;
    w_winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && w_dbl[k]) begin
        w_found  = 1'b1;
        w_sum    = {1'b0, r_rr_ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NREQ)) begin
          w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_winner = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_rr_next = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
    w_sel_pi  = req_pi[w_winner*PI_W +: PI_W];
    w_accept  = (r_state == S_IDLE) && w_found;
    w_rsp_hs  = r_rsp_valid && rsp_ready;
  end

  always_comb begin
    req_ready = '0;
    if (!rst && w_accept) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_dut_pi    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_po    <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dut_pi <= w_sel_pi;
            r_rsp_id <= w_winner;
            r_rr_ptr <= w_rr_next;
            r_cnt    <= 4'(SETTLE);
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_po    <= dut_po;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_pi    = r_dut_pi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_po    = r_rsp_po;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != S_IDLE);

`ifdef APEX7_SIG_EN
  logic [PO_W-1:0] r_sig;

  // Clear wins over a same-cycle handshake update.
  always_ff @(posedge clk) begin
    if (rst || sig_clr) begin
      r_sig <= '0;
    end else if (w_rsp_hs) begin
      r_sig <= {r_sig[PO_W-2:0], r_sig[PO_W-1] ^ r_sig[PO_W-3]} ^ r_rsp_po;
    end
  end

  assign sig = r_sig;
`endif

endmodule

// File: tb/tb_apex7_eval_sched.sv
// Randomized scoreboard bench for apex7_eval_sched with a stand-in apex7 function.
module tb_apex7_eval_sched;

  localparam int NREQ   = 4;
  localparam int PI_W   = 49;
  localparam int PO_W   = 37;
  localparam int SETTLE = 2;

  typedef logic [PI_W-1:0] pi_t;
  typedef logic [PO_W-1:0] po_t;
  typedef struct packed {
    logic [1:0] id;
    po_t        po;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*PI_W-1:0] req_pi = '0;
  pi_t                  dut_pi;
  po_t                  dut_po;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  po_t                  rsp_po;
  logic [1:0]           rsp_id;
  logic                 busy;
  logic                 sig_clr = 1'b0;
`ifdef APEX7_SIG_EN
  po_t                  sig;
`endif

  always #5 clk = ~clk;

  // Stand-in apex7 netlist: po00=pi36, po20=pi07&~pi12, others a fixed permutation/xor.
  function automatic po_t apex7_ref(input pi_t pi);
    po_t po;
    for (int j = 0; j < PO_W; j++) po[j] = pi[(j + 36) % PI_W];
    for (int j = 21; j <= 32; j++) po[j] = po[j] ^ pi[j + 3];
    po[20] = pi[7] & ~pi[12];
    return po;
  endfunction

  function automatic po_t misr_next(input po_t s, input po_t d);
    return {s[PO_W-2:0], s[PO_W-1] ^ s[PO_W-3]} ^ d;
  endfunction

  function automatic pi_t rand_pi();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return x[PI_W-1:0];
  endfunction

  assign dut_po = apex7_ref(dut_pi);

  apex7_eval_sched #(
    .NREQ  (NREQ),
    .PI_W  (PI_W),
    .PO_W  (PO_W),
    .SETTLE(SETTLE)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_pi   (req_pi),
    .dut_pi   (dut_pi),
    .dut_po   (dut_po),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_po   (rsp_po),
    .rsp_id   (rsp_id),
    .busy     (busy)
`ifdef APEX7_SIG_EN
    ,
    .sig_clr  (sig_clr),
    .sig      (sig)
`endif
  );

  // Requester queues, scoreboard and abstract model state (0 idle, 1 settling, 2 responding).
  pi_t         pend[NREQ][$];
  exp_t        sb[$];
  int unsigned dut_grants[$];
  int          total = 0;
  int          bad = 0;
  int          m_state = 0;
  int          m_wait = 0;
  int          m_rr = 0;
  po_t         m_cur_po = '0;
  po_t         m_sig = '0;
  pi_t         m_pi = '0;
  bit          rr_always = 1'b1;
  int          stall_left = 0;
  bit          post_rst = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(m_rr + k) % NREQ].size() != 0) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit do_rst, input bit clr);
    int              w;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    @(negedge clk);
    rst     = do_rst;
    sig_clr = clr;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (pend[i].size() != 0);
      req_pi[i*PI_W +: PI_W] = req_valid[i] ? pend[i][0] : '0;
    end
    if (m_state == 2 && stall_left > 0) begin
      rsp_ready = 1'b0;
      stall_left--;
    end else begin
      rsp_ready = rr_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    #1;
    if (do_rst) begin
      chk("req_ready_in_rst", 64'(req_ready), 64'd0);
      sb.delete();
      dut_grants.delete();
      m_state  = 0;
      m_wait   = 0;
      m_rr     = 0;
      m_sig    = '0;
      m_pi     = '0;
      m_cur_po = '0;
      post_rst = 1'b1;
      return;
    end
    if (post_rst) begin
      chk("rst_rsp_po", 64'(rsp_po), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      post_rst = 1'b0;
    end
    w = (m_state == 0) ? model_winner() : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(m_state != 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_state == 2));
    chk("dut_pi", 64'(dut_pi), 64'(m_pi));
`ifdef APEX7_SIG_EN
    chk("sig", 64'(sig), 64'(m_sig));
`endif
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grants.push_back(i);
    if (clr) m_sig = '0;
    else if (m_state == 2 && rsp_ready) m_sig = misr_next(m_sig, m_cur_po);
    case (m_state)
      0: if (w >= 0) begin
        m_pi     = pend[w].pop_front();
        m_cur_po = apex7_ref(m_pi);
        e.id     = 2'(w);
        e.po     = m_cur_po;
        sb.push_back(e);
        m_rr     = (w + 1) % NREQ;
        m_wait   = SETTLE + 1;
        m_state  = 1;
      end
      1: begin
        m_wait--;
        if (m_wait == 0) m_state = 2;
      end
      default: if (rsp_ready) m_state = 0;
    endcase
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((m_state != 0 || any_pend()) && n < max_cyc) begin
      step(1'b0, 1'b0);
      n++;
    end
    total++;
    if (m_state != 0 || any_pend()) begin
      bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max_cyc);
    end
  endtask

  task automatic run_until_state(input int s, input int max_cyc);
    int n = 0;
    while (m_state != s && n < max_cyc) begin
      step(1'b0, 1'b0);
      n++;
    end
    total++;
    if (m_state != s) begin
      bad++;
      $display("FAIL wait_state_timeout: model state %0d, required %0d", m_state, s);
    end
  endtask

  // Response monitor: pops the scoreboard on each handshake, checks hold while stalled.
  po_t        prev_po;
  logic [1:0] prev_id;
  bit         have_prev = 1'b0;
  exp_t       mon_e;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      have_prev = 1'b0;
    end else if (rsp_valid) begin
      if (have_prev) begin
        chk("hold_rsp_po", 64'(rsp_po), 64'(prev_po));
        chk("hold_rsp_id", 64'(rsp_id), 64'(prev_id));
      end
      if (rsp_ready) begin
        have_prev = 1'b0;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got id %0d po 0x%0h, required no response", rsp_id, rsp_po);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          chk("rsp_po", 64'(rsp_po), 64'(mon_e.po));
        end
      end else begin
        prev_po   = rsp_po;
        prev_id   = rsp_id;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    pi_t v;
    int  exp_order[5];
    int  r;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset with a request already pending, then single request pi36 -> po00.
    v = '0;
    v[36] = 1'b1;
    pend[0].push_back(v);
    repeat (3) step(1'b1, 1'b0);
    rr_always = 1'b1;
    drain(50);

    // Requester 2: pi07 alone, then with pi12.
    v = '0;
    v[7] = 1'b1;
    pend[2].push_back(v);
    drain(50);
    v[12] = 1'b1;
    pend[2].push_back(v);
    drain(50);

    // Fairness from rr_ptr=0 with everyone continuously valid.
    step(1'b1, 1'b0);
    for (int i = 0; i < NREQ; i++) repeat (2) pend[i].push_back(rand_pi());
    drain(200);
    total++;
    if (dut_grants.size() < 5) begin
      bad++;
      $display("FAIL grant_count: got %0d grants, required at least 5", dut_grants.size());
    end else begin
      for (int i = 0; i < 5; i++) chk("grant_order", 64'(dut_grants[i]), 64'(exp_order[i]));
    end

    // Consumer stalls five cycles in RESP.
    stall_left = 5;
    pend[1].push_back(rand_pi());
    drain(50);
    stall_left = 0;

    // Reset while settling: the accepted request is dropped silently.
    pend[3].push_back(rand_pi());
    run_until_state(1, 20);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Random traffic with random consumer backpressure.
    rr_always = 1'b0;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, NREQ - 1);
        if (pend[r].size() < 3) pend[r].push_back(rand_pi());
      end
      step(1'b0, $urandom_range(0, 15) == 0);
    end
    rr_always = 1'b1;
    drain(500);

`ifdef APEX7_SIG_EN
    step(1'b0, 1'b1);
    for (int b = 36; b <= 38; b++) begin
      v = '0;
      v[b] = 1'b1;
      pend[0].push_back(v);
      drain(50);
    end
    pend[1].push_back(rand_pi());
    run_until_state(2, 20);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("sig_clr_priority", 64'(sig), 64'd0);
`endif

    repeat (3) step(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
